// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port among
//            NUM_REQ writeback sources, with a registered grant and x0 discard.
//            Optional stall counters are enabled by REGFILE_WB_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [5*NUM_REQ-1:0]     req_dest,
    input  logic [32*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     wb_load,
    output logic [4:0]               wb_dest,
    output logic [31:0]              wb_data,
    output logic [IDX_W-1:0]         wb_src,
    input  logic                     perf_clr,
    output logic [CNT_W*NUM_REQ-1:0] stall_cnt
);

    localparam logic [IDX_W:0] c_NUM_REQ = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0] last_grant_q;
    logic             wb_load_q;
    logic [4:0]       wb_dest_q;
    logic [31:0]      wb_data_q;
    logic [IDX_W-1:0] wb_src_q;

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_any;
    logic             w_grant;
    logic [4:0]       w_win_dest;
    logic [31:0]      w_win_data;

    // Scan from the slot after the last winner, wrapping once around.
    always_comb begin
        w_sum     = '0;
        w_win_idx = '0;
        w_win_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, last_grant_q} + (IDX_W+1)'(k + 1);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_win_any && req_valid[w_sum[IDX_W-1:0]]) begin
                w_win_any = 1'b1;
                w_win_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    // rst_n gates the grant so nothing is accepted while the port is held in reset.
    assign w_grant    = w_win_any && !flush && rst_n;
    assign w_win_dest = req_dest[5*int'(w_win_idx) +: 5];
    assign w_win_data = req_data[32*int'(w_win_idx) +: 32];

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            wb_load_q    <= 1'b0;
            wb_dest_q    <= '0;
            wb_data_q    <= '0;
            wb_src_q     <= '0;
        end else begin
            wb_load_q <= w_grant && (w_win_dest != 5'd0);
            if (w_grant) begin
                last_grant_q <= w_win_idx;
                wb_dest_q    <= w_win_dest;
                wb_data_q    <= w_win_data;
                wb_src_q     <= w_win_idx;
            end
        end
    end

    assign wb_load = wb_load_q;
    assign wb_dest = wb_dest_q;
    assign wb_data = wb_data_q;
    assign wb_src  = wb_src_q;

`ifdef REGFILE_WB_ARB_PERF_EN
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (perf_clr) begin
                    cnt_q <= '0;
                end else if (req_valid[i] && !req_ready[i] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign stall_cnt[CNT_W*i +: CNT_W] = cnt_q;
        end
    endgenerate
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = perf_clr;
    assign stall_cnt         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter: directed scenarios
//            plus random traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N    = 3;
    localparam int CW   = 4;
    localparam int IW   = $clog2(N);
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            perf_clr = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [5*N-1:0]  req_dest = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wb_load;
    logic [4:0]      wb_dest;
    logic [31:0]     wb_data;
    logic [IW-1:0]   wb_src;
    logic [CW*N-1:0] stall_cnt;

    regfile_wb_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready), .wb_load(wb_load), .wb_dest(wb_dest),
        .wb_data(wb_data), .wb_src(wb_src),
        .perf_clr(perf_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_last;
    logic        m_load;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    int          m_src;
    int          m_cnt [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_load = 1'b0;
        m_dest = '0;
        m_data = '0;
        m_src  = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Winner = valid requester closest after the last winner in circular order.
    function automatic int model_winner(input logic [N-1:0] v);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d = (i - m_last - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // One clock cycle: apply inputs at negedge, check outputs, advance model.
    task automatic cycle(input logic [N-1:0] v, input logic f, input logic c,
                         input logic [5*N-1:0] d, input logic [32*N-1:0] dt,
                         output int win);
        logic [N-1:0]    exp_ready;
        logic [CW*N-1:0] exp_sc;
        @(negedge clk);
        req_valid = v;
        flush     = f;
        perf_clr  = c;
        req_dest  = d;
        req_data  = dt;
        #1;
        win       = f ? -1 : model_winner(v);
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_sc = '0;
        for (int i = 0; i < N; i++) exp_sc[CW*i +: CW] = CW'(m_cnt[i]);
        check_val("req_ready", 64'(req_ready), 64'(exp_ready));
        check_val("wb_load",   64'(wb_load),   64'(m_load));
        check_val("wb_dest",   64'(wb_dest),   64'(m_dest));
        check_val("wb_data",   64'(wb_data),   64'(m_data));
        check_val("wb_src",    64'(wb_src),    64'(m_src));
        check_val("stall_cnt", 64'(stall_cnt), 64'(exp_sc));
`ifdef REGFILE_WB_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            if (c) m_cnt[i] = 0;
            else if (v[i] && win != i && m_cnt[i] < CMAX) m_cnt[i]++;
        end
`endif
        if (win >= 0) begin
            m_load = (d[5*win +: 5] != 5'd0);
            m_dest = d[5*win +: 5];
            m_data = dt[32*win +: 32];
            m_src  = win;
            m_last = win;
        end else begin
            m_load = 1'b0;
        end
    endtask

    logic [5*N-1:0]  dd;
    logic [32*N-1:0] dt;
    logic [N-1:0]    rv;
    int              w;
    logic [N-1:0]    rr_seq [6];
    logic [4:0]      dst_seq [6];

    initial begin
        model_reset();
        req_valid = '1;
        #1;
        check_val("rst_ready", 64'(req_ready), 64'd0);
        check_val("rst_load",  64'(wb_load),   64'd0);
        check_val("rst_dest",  64'(wb_dest),   64'd0);
        check_val("rst_data",  64'(wb_data),   64'd0);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;

        // Round-robin with all valid, dests 5/6/7
        dd = {5'd7, 5'd6, 5'd5};
        dt = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        rr_seq  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        dst_seq = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
            check_val("rr_grant", 64'(req_ready), 64'(rr_seq[k]));
            if (k > 0) begin
                check_val("rr_dest", 64'(wb_dest), 64'(dst_seq[k-1]));
                check_val("rr_load", 64'(wb_load), 64'd1);
            end
        end

        // Wrap and skip from last grant = 2
        cycle(3'b010, 1'b0, 1'b0, dd, dt, w);
        check_val("skip_g1", 64'(req_ready), 64'b010);
        cycle(3'b101, 1'b0, 1'b0, dd, dt, w);
        check_val("skip_g2", 64'(req_ready), 64'b100);
        cycle(3'b101, 1'b0, 1'b0, dd, dt, w);
        check_val("skip_g0", 64'(req_ready), 64'b001);

        // x0 discard
        dd = {5'd7, 5'd0, 5'd5};
        dt = {32'h3333_0002, 32'hDEAD_BEEF, 32'h1111_0000};
        cycle(3'b010, 1'b0, 1'b0, dd, dt, w);
        check_val("x0_grant", 64'(req_ready), 64'b010);
        dd = {5'd7, 5'd9, 5'd5};
        cycle(3'b110, 1'b0, 1'b0, dd, dt, w);
        check_val("x0_load", 64'(wb_load), 64'd0);
        check_val("x0_next", 64'(req_ready), 64'b100);

        // Flush
        cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
        check_val("fl_grantN", 64'(req_ready), 64'b001);
        cycle(3'b111, 1'b1, 1'b0, dd, dt, w);
        check_val("fl_ready", 64'(req_ready), 64'd0);
        check_val("fl_load",  64'(wb_load),   64'd1);
        check_val("fl_src",   64'(wb_src),    64'd0);
        cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
        check_val("fl_after_load",  64'(wb_load),   64'd0);
        check_val("fl_after_grant", 64'(req_ready), 64'b010);

        // Stall counting behind requesters 0 and 1
        cycle(3'b100, 1'b0, 1'b1, dd, dt, w);
        cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
        cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
        cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
        check_val("perf_g2", 64'(req_ready), 64'b100);
`ifdef REGFILE_WB_ARB_PERF_EN
        check_val("perf_cnt2", 64'(stall_cnt[2*CW +: CW]), 64'd2);
`endif

        // Saturation under sustained flush, then clear
        for (int k = 0; k < 20; k++) cycle(3'b111, 1'b1, 1'b0, dd, dt, w);
`ifdef REGFILE_WB_ARB_PERF_EN
        check_val("perf_sat", 64'(stall_cnt), {(64-CW*N)'(0), {(CW*N){1'b1}}});
`endif
        cycle(3'b111, 1'b1, 1'b1, dd, dt, w);
        cycle(3'b000, 1'b0, 1'b0, dd, dt, w);
        check_val("perf_clr", 64'(stall_cnt), 64'd0);

        // Random traffic honouring the requester hold rule
        rv = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rv[i] && w != i) begin
                    if ($urandom_range(0, 7) == 0) rv[i] = 1'b0;
                end else begin
                    rv[i] = ($urandom_range(0, 99) < 60);
                    dd[5*i +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    dt[32*i +: 32] = $urandom;
                end
            end
            cycle(rv, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), dd, dt, w);
        end

        // Mid-cycle asynchronous reset with all requesters valid
        @(negedge clk);
        req_valid = '1;
        flush     = 1'b0;
        perf_clr  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("mrst_ready", 64'(req_ready), 64'd0);
        check_val("mrst_load",  64'(wb_load),   64'd0);
        check_val("mrst_dest",  64'(wb_dest),   64'd0);
        check_val("mrst_data",  64'(wb_data),   64'd0);
        check_val("mrst_stall", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        cycle(3'b111, 1'b0, 1'b0, dd, dt, w);
        check_val("mrst_first", 64'(req_ready), 64'b001);
        cycle(3'b000, 1'b0, 1'b0, dd, dt, w);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
